// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Purpose  : Requester and uart_tx side signals of the round-robin TX arbiter.
//  Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int GW    = $clog2(N_REQ)
);
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   ack;
   logic [N_REQ-1:0]   sent;
   logic [7:0]         tx_data;
   logic               tx_en;
   logic               tx_busy;
   logic               tx_done;
   logic               active;
   logic [GW-1:0]      grant_id;

   modport master (
      input  req, req_data, tx_busy, tx_done,
      output ack, sent, tx_data, tx_en, active, grant_id
   );

   modport slave (
      output req, req_data, tx_busy, tx_done,
      input  ack, sent, tx_data, tx_en, active, grant_id
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin sharing of one uart_tx between N_REQ byte requesters.
//  Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int GW    = $clog2(N_REQ)
) (
   input  wire logic             clk,
   input  wire logic             arst_n,
   uart_tx_arbiter_if.master     bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [GW-1:0]      last_q, last_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_en_q, tx_en_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [N_REQ-1:0]   sent_q, sent_d;

   logic [GW:0]        start;
   logic [2*N_REQ-1:0] rot;
   logic [GW-1:0]      win;
   logic               win_vld;
   int                 pos;

   // Rotate the request vector so bit 0 is the requester just after the last winner.
   always_comb begin
      start   = {1'b0, last_q} + (GW+1)'(1);
      if (start == (GW+1)'(N_REQ)) begin
         start = '0;
      end
      rot     = {bus.req, bus.req} >> start;
      win     = '0;
      win_vld = 1'b0;
      pos     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_vld && rot[i]) begin
            pos = int'(start) + i;
            if (pos >= N_REQ) begin
               pos = pos - N_REQ;
            end
            win     = GW'(pos);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      tx_data_d = tx_data_q;
      tx_en_d   = 1'b0;
      ack_d     = '0;
      sent_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d = S_LAUNCH;
               last_d  = win;
               grant_d = win;
               tx_en_d = 1'b1;
               for (int j = 0; j < N_REQ; j++) begin
                  if (GW'(j) == win) begin
                     tx_data_d = bus.req_data[j*8 +: 8];
                     ack_d[j]  = 1'b1;
                  end
               end
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY, S_WAIT_DONE: begin
            // A done seen before busy (very short frame) still completes the transfer.
            if (bus.tx_done) begin
               state_d = S_IDLE;
               for (int j = 0; j < N_REQ; j++) begin
                  sent_d[j] = (GW'(j) == grant_q);
               end
            end else if (state_q == S_WAIT_BUSY && bus.tx_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= S_IDLE;
         last_q    <= GW'(N_REQ - 1);
         grant_q   <= '0;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
         ack_q     <= '0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         ack_q     <= ack_d;
         sent_q    <= sent_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.sent     = sent_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_en    = tx_en_q;
   assign bus.grant_id = grant_q;
   assign bus.active   = (state_q != S_IDLE);

endmodule
`default_nettype wire
